// File: rtl/regfile_mp_if.sv
// Bus bundle between the ID/WB stages and regfile_mp: write-back, read ports,
// issue scoreboard updates and EPC capture inputs.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
);
   logic                    we;
   logic [ADDR_W-1:0]       waddr;
   logic [DATA_W-1:0]       wdata;
   logic [NRD-1:0]          re;
   logic [NRD*ADDR_W-1:0]   raddr;
   logic [NRD*DATA_W-1:0]   rdata;
   logic [NRD-1:0]          rbusy;
   logic                    iss_we;
   logic [ADDR_W-1:0]       iss_addr;
   logic                    be;
   logic [DATA_W-1:0]       baddr;
   logic [DATA_W-1:0]       pc;
   logic                    irq;
   logic [DATA_W-1:0]       epc_out;

   modport master (
      output we, waddr, wdata, re, raddr, iss_we, iss_addr, be, baddr, pc, irq,
      input  rdata, rbusy, epc_out
   );

   modport slave (
      input  we, waddr, wdata, re, raddr, iss_we, iss_addr, be, baddr, pc, irq,
      output rdata, rbusy, epc_out
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with WB forwarding, busy scoreboard and
// interrupt-captured EPC register. Define RF_EPC_WRITE_EN to let WB write the EPC.
module regfile_mp #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NRD     = 2,
   parameter int EPC_IDX = 26
) (
   input logic        clk,
   input logic        rst,
   regfile_mp_if.slave bus
);
   localparam int              DEPTH  = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] EPC_A  = ADDR_W'(EPC_IDX);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DEPTH-1:0]  busy_q;
   logic [DEPTH-1:0]  busy_d;
   logic              wr_acc_s;
   logic              wr_nz_s;
   logic [ADDR_W-1:0] ra_s;
   logic [NRD*DATA_W-1:0] rdata_s;
   logic [NRD-1:0]    rbusy_s;
   logic [DATA_W-1:0] epc_cap_s;
   logic              unused_pc_msb_s;

   assign wr_nz_s = bus.we && (bus.waddr != ZERO_A);
`ifdef RF_EPC_WRITE_EN
   // An interrupt capture on the same edge owns the EPC, so the WB write loses.
   assign wr_acc_s = wr_nz_s && !((bus.waddr == EPC_A) && bus.irq);
`else
   assign wr_acc_s = wr_nz_s && (bus.waddr != EPC_A);
`endif

   assign epc_cap_s       = bus.be ? bus.baddr : {1'b0, bus.pc[DATA_W-2:0]};
   assign unused_pc_msb_s = bus.pc[DATA_W-1];

   // Next-state of register array and scoreboard
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (wr_acc_s) begin
         regs_d[bus.waddr] = bus.wdata;
      end else begin
         regs_d[bus.waddr] = regs_q[bus.waddr];
      end
      regs_d[EPC_A] = bus.irq ? epc_cap_s : regs_d[EPC_A];
      regs_d[0]     = {DATA_W{1'b0}};

      if (bus.irq) begin
         busy_d = {DEPTH{1'b0}};
      end else begin
         if (wr_nz_s) begin
            busy_d[bus.waddr] = 1'b0;
         end else begin
            busy_d[bus.waddr] = busy_d[bus.waddr];
         end
         if (bus.iss_we && (bus.iss_addr != ZERO_A)) begin
            busy_d[bus.iss_addr] = 1'b1;
         end else begin
            busy_d[bus.iss_addr] = busy_d[bus.iss_addr];
         end
      end
      busy_d[0] = 1'b0;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= {DATA_W{1'b0}};
         end
         busy_q <= {DEPTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= regs_d[i];
         end
         busy_q <= busy_d;
      end
   end

   // Read ports: combinational with WB forwarding and hazard flag
   always_comb begin
      rdata_s = {(NRD*DATA_W){1'b0}};
      rbusy_s = {NRD{1'b0}};
      ra_s    = ZERO_A;
      for (int k = 0; k < NRD; k++) begin
         ra_s = bus.raddr[k*ADDR_W +: ADDR_W];
         if (rst || (ra_s == ZERO_A) || !bus.re[k]) begin
            rdata_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            rbusy_s[k]                  = 1'b0;
         end else if (wr_acc_s && (bus.waddr == ra_s)) begin
            rdata_s[k*DATA_W +: DATA_W] = bus.wdata;
            rbusy_s[k]                  = 1'b0;
         end else begin
            rdata_s[k*DATA_W +: DATA_W] = regs_q[ra_s];
            // A same-cycle WB to this register resolves the hazard even if not stored.
            rbusy_s[k] = busy_q[ra_s] && !(wr_nz_s && (bus.waddr == ra_s));
         end
      end
   end

   assign bus.rdata   = rdata_s;
   assign bus.rbusy   = rbusy_s;
   assign bus.epc_out = rst ? {DATA_W{1'b0}} : regs_q[EPC_A];
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the pipeline's integer register file.
- Sits between ID (reads, issue) and WB (write-back).
- Adds N read ports, a per-register busy scoreboard for ID hazard detection, and a protected EPC register captured on timer interrupt.
- Reads are combinational with WB-to-ID forwarding. Writes, scoreboard updates and EPC capture take effect on the clock edge.

Parameters:
DATA_W, 32, register width in bits (minimum 2)
ADDR_W, 5, register address width; depth = 2**ADDR_W, entry 0 hard-wired to zero
NRD, 2, number of read ports (1..4)
EPC_IDX, 26, index of the protected EPC register (must be non-zero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
we  in  1  WB write enable
waddr  in  ADDR_W  WB write address
wdata  in  DATA_W  WB write data
re  in  NRD  per-port read enable
raddr  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rdata  out  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
rbusy  out  NRD  port k source register has an outstanding producer
iss_we  in  1  ID issued an instruction that will write iss_addr
iss_addr  in  ADDR_W  destination register of the issued instruction
be  in  1  ID branch taken this cycle
baddr  in  DATA_W  ID branch target
pc  in  DATA_W  current PC
irq  in  1  timer interrupt taken this cycle (EPC capture strobe)
epc_out  out  DATA_W  current EPC register contents

Behaviour:
- Reset (rst=1 at clk edge): all registers 1..depth-1 become 0 and all busy bits become 0. rst takes priority over every other input that cycle.
- While rst=1, rdata, rbusy and epc_out are forced to 0 combinationally.
- Read port k, priority order:
  - rst=1 -> rdata=0.
  - raddr_k=0 -> 0.
  - re_k=0 -> 0.
  - we=1 and waddr=raddr_k and the write is accepted -> wdata (forwarding).
  - Otherwise -> stored value. Zero added latency.
- Write accepted when we=1, waddr!=0 and waddr!=EPC_IDX. The register updates at the next edge.
- EPC capture on an edge with irq=1:
  - be=1 -> reg[EPC_IDX] <= baddr.
  - be=0 -> reg[EPC_IDX] <= {1'b0, pc[DATA_W-2:0]}.
  - Capture happens regardless of we. A simultaneous normal write to another register still completes.
- epc_out = reg[EPC_IDX], registered value, with no forwarding of the capture in progress.
- Scoreboard, one busy bit per register, bit 0 always 0. At each edge, in priority order:
  - irq=1 -> all busy bits clear (pipeline flush); iss_we ignored.
  - Otherwise, if we=1 and waddr!=0 -> busy[waddr] clears.
  - Then, if iss_we=1 and iss_addr!=0 -> busy[iss_addr] sets. Set wins over clear on the same address (a new producer was issued).
  - The EPC index participates in the scoreboard like any other register.
- rbusy_k = re_k & busy[raddr_k] & ~(we & waddr==raddr_k & waddr!=0). Forwarding resolves the hazard in the same cycle. rbusy_k=0 when raddr_k=0.
- Write to address 0 is discarded; no scoreboard or data effect.
- Multiple read ports may address the same register; all return identical data.

Optional Feature:
RF_EPC_WRITE_EN
- Defined:
  - WB writes to EPC_IDX are accepted and forwarded like any register.
  - If irq=1 on the same edge, the interrupt capture wins and the WB write is dropped.
  - The forwarding path is suppressed when irq=1.
- Undefined: writes to EPC_IDX are silently discarded; EPC changes only on irq or rst.

Test Plan:
- Reset then read: rst=1 one cycle, then read r1..r31 on all ports with re=all-ones -> every rdata=0, rbusy=0, epc_out=0.
- Write/forward: we=1, waddr=5, wdata=32'hDEADBEEF, raddr0=5 same cycle -> rdata0=DEADBEEF combinationally; the next cycle with we=0 -> still DEADBEEF. raddr1=0 concurrently -> 0.
- Scoreboard:
  - iss_we=1, iss_addr=7 -> next cycle rbusy for raddr=7 is 1.
  - WB we=1, waddr=7 -> rbusy=0 that same cycle via forwarding; busy bit clear afterwards.
  - Same-cycle iss_addr=7 and waddr=7 -> busy remains 1.
- EPC capture:
  - irq=1, be=0, pc=32'h8000_0040 -> epc_out=32'h0000_0040 next cycle.
  - irq=1, be=1, baddr=32'h0000_1000 -> epc_out=32'h0000_1000.
  - irq with busy bits set -> all rbusy=0 next cycle.
- EPC protection: we=1, waddr=26, wdata=32'h1234 with macro undefined -> reg26 unchanged. With RF_EPC_WRITE_EN -> reg26=32'h1234. With RF_EPC_WRITE_EN plus a simultaneous irq -> irq value wins.
- Reset mid-operation: busy bits set and registers written, then rst=1 while we=1 and iss_we=1 -> all zero next cycle; neither the write nor the busy-set takes effect.
